// File: rtl/mem_xbar_pkg.sv
// mem_xbar_pkg: shared FSM states, master indices and limits for the crossbar
package mem_xbar_pkg;
  typedef enum logic [1:0] {IDLE, PEND, BUSY, DERR} st_e;
  localparam int IMST = 0;
  localparam int DMST = 1;
  localparam int MAX_NSLV = 8;
  function automatic int oh2idx(input logic [MAX_NSLV-1:0] oh);
    oh2idx = 0;
    for (int i = 0; i < MAX_NSLV; i++) if (oh[i]) oh2idx = i;
  endfunction
endpackage

// File: rtl/mem_xbar_dec.sv
// mem_xbar_dec: address decoder giving one-hot region hit (lowest index wins), miss flag and region offset
module mem_xbar_dec #(
  parameter int NSLV = 4,
  parameter int ADDR_W = 32,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NSLV*ADDR_W-1:0] SLV_SIZE = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [NSLV-1:0]   hit_o,
  output logic              miss_o,
  output logic [ADDR_W-1:0] off_o
);
  // scan from the top so the lowest matching region overrides the others
  always_comb begin
    hit_o = '0;
    miss_o = 1'b1;
    off_o = '0;
    for (int i = NSLV - 1; i >= 0; i--)
      if (addr_i >= SLV_BASE[i*ADDR_W +: ADDR_W] &&
          addr_i - SLV_BASE[i*ADDR_W +: ADDR_W] < SLV_SIZE[i*ADDR_W +: ADDR_W]) begin
        hit_o = '0;
        hit_o[i] = 1'b1;
        miss_o = 1'b0;
        off_o = addr_i - SLV_BASE[i*ADDR_W +: ADDR_W];
      end
  end
endmodule

// File: rtl/mem_xbar.sv
// mem_xbar: 2-master x NSLV-slave memory crossbar; define MEM_XBAR_RR_EN for per-slave round-robin, else data master has fixed priority
module mem_xbar import mem_xbar_pkg::*; #(
  parameter int NSLV = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NSLV*ADDR_W-1:0] SLV_SIZE = {4{32'h1000_0000}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     imemory_valid,
  input  logic                     imemory_instr,
  input  logic [ADDR_W-1:0]        imemory_addr,
  input  logic [DATA_W-1:0]        imemory_wdata,
  input  logic [DATA_W/8-1:0]      imemory_wstrb,
  output logic [DATA_W-1:0]        imemory_rdata,
  output logic                     imemory_ready,
  output logic                     imemory_err,
  input  logic                     dmemory_valid,
  input  logic                     dmemory_instr,
  input  logic [ADDR_W-1:0]        dmemory_addr,
  input  logic [DATA_W-1:0]        dmemory_wdata,
  input  logic [DATA_W/8-1:0]      dmemory_wstrb,
  output logic [DATA_W-1:0]        dmemory_rdata,
  output logic                     dmemory_ready,
  output logic                     dmemory_err,
  output logic [NSLV-1:0]          slv_valid,
  output logic [NSLV-1:0]          slv_instr,
  output logic [NSLV*ADDR_W-1:0]   slv_addr,
  output logic [NSLV*DATA_W-1:0]   slv_wdata,
  output logic [NSLV*DATA_W/8-1:0] slv_wstrb,
  input  logic [NSLV*DATA_W-1:0]   slv_rdata,
  input  logic [NSLV-1:0]          slv_ready
);
  localparam int SW = DATA_W / 8;
  localparam int IW = NSLV > 1 ? $clog2(NSLV) : 1;
  logic              m_valid [2];
  logic              m_instr [2];
  logic [ADDR_W-1:0] m_addr  [2];
  logic [DATA_W-1:0] m_wdata [2];
  logic [SW-1:0]     m_wstrb [2];
  logic [NSLV-1:0]   d_hit   [2];
  logic              d_miss  [2];
  logic [ADDR_W-1:0] d_off   [2];
  st_e               st_q      [2];
  logic [NSLV-1:0]   l_hit_q   [2];
  logic              l_instr_q [2];
  logic [ADDR_W-1:0] l_off_q   [2];
  logic [DATA_W-1:0] l_wdata_q [2];
  logic [SW-1:0]     l_wstrb_q [2];
  logic [IW-1:0]     own_q     [2];
  logic              r_v     [2];
  logic [NSLV-1:0]   r_hit   [2];
  logic              r_instr [2];
  logic [ADDR_W-1:0] r_off   [2];
  logic [DATA_W-1:0] r_wdata [2];
  logic [SW-1:0]     r_wstrb [2];
  logic [NSLV-1:0]   gnt     [2];
  logic              g_v     [2];
  logic [DATA_W-1:0] rsp_rdata [2];
  logic              rsp_ready [2];
  logic              rsp_err   [2];
  logic [NSLV-1:0]   want_i, want_d, sel_d, busy_q, issue;
`ifdef MEM_XBAR_RR_EN
  logic [NSLV-1:0]   ptr_q;
  logic [NSLV-1:0]   cont;
`endif
  assign m_valid[IMST] = imemory_valid;
  assign m_instr[IMST] = imemory_instr;
  assign m_addr[IMST]  = imemory_addr;
  assign m_wdata[IMST] = imemory_wdata;
  assign m_wstrb[IMST] = imemory_wstrb;
  assign m_valid[DMST] = dmemory_valid;
  assign m_instr[DMST] = dmemory_instr;
  assign m_addr[DMST]  = dmemory_addr;
  assign m_wdata[DMST] = dmemory_wdata;
  assign m_wstrb[DMST] = dmemory_wstrb;
  assign imemory_rdata = rsp_rdata[IMST];
  assign imemory_ready = rsp_ready[IMST];
  assign imemory_err   = rsp_err[IMST];
  assign dmemory_rdata = rsp_rdata[DMST];
  assign dmemory_ready = rsp_ready[DMST];
  assign dmemory_err   = rsp_err[DMST];
  for (genvar m = 0; m < 2; m++) begin : g_dec
    mem_xbar_dec #(.NSLV(NSLV), .ADDR_W(ADDR_W), .SLV_BASE(SLV_BASE), .SLV_SIZE(SLV_SIZE)) u_dec (
      .addr_i(m_addr[m]), .hit_o(d_hit[m]), .miss_o(d_miss[m]), .off_o(d_off[m])
    );
  end
  // active request per master: a fresh mapped pulse in IDLE, or the latched one in PEND
  always_comb begin
    for (int m = 0; m < 2; m++) begin
      r_v[m]     = st_q[m] == PEND || (st_q[m] == IDLE && m_valid[m] && !d_miss[m]);
      r_hit[m]   = st_q[m] == PEND ? l_hit_q[m]   : d_hit[m];
      r_instr[m] = st_q[m] == PEND ? l_instr_q[m] : m_instr[m];
      r_off[m]   = st_q[m] == PEND ? l_off_q[m]   : d_off[m];
      r_wdata[m] = st_q[m] == PEND ? l_wdata_q[m] : m_wdata[m];
      r_wstrb[m] = st_q[m] == PEND ? l_wstrb_q[m] : m_wstrb[m];
    end
  end
  // per-slave arbitration; a slave is only granted while free
  always_comb begin
    want_i = r_v[IMST] ? r_hit[IMST] : '0;
    want_d = r_v[DMST] ? r_hit[DMST] : '0;
`ifdef MEM_XBAR_RR_EN
    sel_d = want_d & (~want_i | ptr_q);
    cont  = ~busy_q & want_i & want_d;
`else
    sel_d = want_d;
`endif
    gnt[DMST] = ~busy_q & sel_d;
    gnt[IMST] = ~busy_q & want_i & ~sel_d;
    issue = gnt[DMST] | gnt[IMST];
    g_v[DMST] = |gnt[DMST];
    g_v[IMST] = |gnt[IMST];
  end
  // slave request channels, zero whenever no request is issued or reset is held
  always_comb begin
    slv_valid = '0;
    slv_instr = '0;
    slv_addr  = '0;
    slv_wdata = '0;
    slv_wstrb = '0;
    for (int s = 0; s < NSLV; s++)
      if (rst && issue[s]) begin
        slv_valid[s] = 1'b1;
        slv_instr[s] = sel_d[s] ? r_instr[DMST] : r_instr[IMST];
        slv_addr[s*ADDR_W +: ADDR_W] = sel_d[s] ? r_off[DMST] : r_off[IMST];
        slv_wdata[s*DATA_W +: DATA_W] = sel_d[s] ? r_wdata[DMST] : r_wdata[IMST];
        slv_wstrb[s*SW +: SW] = sel_d[s] ? r_wstrb[DMST] : r_wstrb[IMST];
      end
  end
  // master responses: owning slave routed through in BUSY, error beat in DERR
  always_comb begin
    for (int m = 0; m < 2; m++) begin
      rsp_rdata[m] = (rst && st_q[m] == BUSY) ? slv_rdata[int'(own_q[m])*DATA_W +: DATA_W] : '0;
      rsp_ready[m] = rst && ((st_q[m] == BUSY && slv_ready[own_q[m]]) || st_q[m] == DERR);
      rsp_err[m]   = rst && st_q[m] == DERR;
    end
  end
  // per-master FSM with request latch and owned-slave index
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        st_q[m] <= IDLE;
        l_hit_q[m] <= '0;
        l_instr_q[m] <= 1'b0;
        l_off_q[m] <= '0;
        l_wdata_q[m] <= '0;
        l_wstrb_q[m] <= '0;
        own_q[m] <= '0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (st_q[m] == IDLE && m_valid[m]) begin
          l_hit_q[m] <= d_hit[m];
          l_instr_q[m] <= m_instr[m];
          l_off_q[m] <= d_off[m];
          l_wdata_q[m] <= m_wdata[m];
          l_wstrb_q[m] <= m_wstrb[m];
        end
        if (g_v[m]) own_q[m] <= IW'(oh2idx(MAX_NSLV'(r_hit[m])));
        case (st_q[m])
          IDLE: if (m_valid[m]) st_q[m] <= d_miss[m] ? DERR : g_v[m] ? BUSY : PEND;
          PEND: if (g_v[m]) st_q[m] <= BUSY;
          BUSY: if (slv_ready[own_q[m]]) st_q[m] <= IDLE;
          default: st_q[m] <= IDLE;
        endcase
      end
    end
  // slave occupancy from issue through its ready beat
  always_ff @(posedge clk or negedge rst)
    if (!rst) busy_q <= '0;
    else busy_q <= issue | (busy_q & ~slv_ready);
`ifdef MEM_XBAR_RR_EN
  // pointer bit set means the data master wins the next contention on that slave
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr_q <= '1;
    else ptr_q <= (ptr_q & ~cont) | (~sel_d & cont);
`endif
endmodule

// File: tb/tb_mem_xbar.sv
// tb_mem_xbar: scoreboard bench for mem_xbar with slave models and directed vectors
module tb_mem_xbar;
  localparam int NSLV = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  typedef struct {logic instr; logic [31:0] off; logic [31:0] wdata; logic [3:0] wstrb;} iss_t;
  typedef struct {logic [31:0] rdata; logic err;} rsp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic imemory_valid = 1'b0, imemory_instr = 1'b0;
  logic [AW-1:0] imemory_addr = '0;
  logic [DW-1:0] imemory_wdata = '0;
  logic [3:0] imemory_wstrb = '0;
  logic dmemory_valid = 1'b0, dmemory_instr = 1'b0;
  logic [AW-1:0] dmemory_addr = '0;
  logic [DW-1:0] dmemory_wdata = '0;
  logic [3:0] dmemory_wstrb = '0;
  logic [DW-1:0] imemory_rdata, dmemory_rdata;
  logic imemory_ready, imemory_err, dmemory_ready, dmemory_err;
  logic [NSLV-1:0] slv_valid, slv_instr;
  logic [NSLV*AW-1:0] slv_addr;
  logic [NSLV*DW-1:0] slv_wdata;
  logic [NSLV*DW/8-1:0] slv_wstrb;
  logic [NSLV*DW-1:0] slv_rdata = '0;
  logic [NSLV-1:0] slv_ready = '0;
  iss_t exp_iss [NSLV][$];
  rsp_t exp_i [$];
  rsp_t exp_d [$];
  int iss_log [NSLV][$];
  int rdy_log [NSLV][$];
  logic [31:0] rd_base [NSLV] = '{32'h1234_5638, 32'hA000_0000, 32'hB000_0000, 32'hC000_0000};
  int lat [NSLV] = '{1, 1, 1, 1};
  int cnt [NSLV] = '{0, 0, 0, 0};
  logic got [NSLV] = '{0, 0, 0, 0};
  logic [31:0] last_off [NSLV];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mem_xbar dut (
    .clk(clk), .rst(rst),
    .imemory_valid(imemory_valid), .imemory_instr(imemory_instr), .imemory_addr(imemory_addr),
    .imemory_wdata(imemory_wdata), .imemory_wstrb(imemory_wstrb),
    .imemory_rdata(imemory_rdata), .imemory_ready(imemory_ready), .imemory_err(imemory_err),
    .dmemory_valid(dmemory_valid), .dmemory_instr(dmemory_instr), .dmemory_addr(dmemory_addr),
    .dmemory_wdata(dmemory_wdata), .dmemory_wstrb(dmemory_wstrb),
    .dmemory_rdata(dmemory_rdata), .dmemory_ready(dmemory_ready), .dmemory_err(dmemory_err),
    .slv_valid(slv_valid), .slv_instr(slv_instr), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
    .slv_wstrb(slv_wstrb), .slv_rdata(slv_rdata), .slv_ready(slv_ready)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // monitor: pops expected slave requests and master responses as the DUT presents them
  always @(negedge clk) begin
    iss_t e;
    rsp_t r;
    for (int s = 0; s < NSLV; s++) begin
      if (slv_ready[s]) rdy_log[s].push_back(cyc);
      if (slv_valid[s]) begin
        got[s] = 1'b1;
        last_off[s] = slv_addr[s*AW +: AW];
        iss_log[s].push_back(cyc);
        if (exp_iss[s].size() == 0) chk($sformatf("unexpected slv_valid[%0d]", s), 1, 0);
        else begin
          e = exp_iss[s].pop_front();
          chk($sformatf("slv%0d instr", s), slv_instr[s], e.instr);
          chk($sformatf("slv%0d addr", s), slv_addr[s*AW +: AW], e.off);
          chk($sformatf("slv%0d wdata", s), slv_wdata[s*DW +: DW], e.wdata);
          chk($sformatf("slv%0d wstrb", s), slv_wstrb[s*4 +: 4], e.wstrb);
        end
      end
    end
    if (imemory_ready) begin
      if (exp_i.size() == 0) chk("unexpected imemory_ready", 1, 0);
      else begin
        r = exp_i.pop_front();
        chk("imemory rdata/err", {imemory_rdata, imemory_err}, {r.rdata, r.err});
      end
    end
    if (dmemory_ready) begin
      if (exp_d.size() == 0) chk("unexpected dmemory_ready", 1, 0);
      else begin
        r = exp_d.pop_front();
        chk("dmemory rdata/err", {dmemory_rdata, dmemory_err}, {r.rdata, r.err});
      end
    end
  end
  // slave models: answer each request after lat cycles with rd_base + offset
  always @(posedge clk) begin
    #2;
    for (int s = 0; s < NSLV; s++) begin
      slv_ready[s] = 1'b0;
      slv_rdata[s*DW +: DW] = '0;
      if (got[s]) begin
        got[s] = 1'b0;
        cnt[s] = lat[s];
      end
      if (cnt[s] > 0) begin
        cnt[s]--;
        if (cnt[s] == 0) begin
          slv_ready[s] = 1'b1;
          slv_rdata[s*DW +: DW] = rd_base[s] + last_off[s];
        end
      end
    end
  end
  function automatic int pending();
    int p = exp_i.size() + exp_d.size();
    for (int s = 0; s < NSLV; s++) p += exp_iss[s].size() + int'(cnt[s] != 0) + int'(got[s]);
    return p;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
    imemory_valid = 1'b0;
    dmemory_valid = 1'b0;
  endtask
  task automatic req(input logic d, input logic instr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    if (d) begin
      dmemory_valid = 1'b1; dmemory_instr = instr; dmemory_addr = a; dmemory_wdata = wd; dmemory_wstrb = ws;
    end else begin
      imemory_valid = 1'b1; imemory_instr = instr; imemory_addr = a; imemory_wdata = wd; imemory_wstrb = ws;
    end
  endtask
  task automatic exp_issue(input int s, input logic instr, input logic [31:0] off, input logic [31:0] wd, input logic [3:0] ws);
    iss_t e;
    e.instr = instr; e.off = off; e.wdata = wd; e.wstrb = ws;
    exp_iss[s].push_back(e);
  endtask
  task automatic exp_rsp(input logic d, input logic [31:0] rdata, input logic err);
    rsp_t r;
    r.rdata = rdata; r.err = err;
    if (d) exp_d.push_back(r);
    else exp_i.push_back(r);
  endtask
  task automatic drain(input string nm);
    int k = 0;
    while (pending() != 0 && k < 100) begin
      tick();
      k++;
    end
    chk({nm, " outstanding after drain"}, pending(), 0);
    tick();
  endtask
  function automatic logic [63:0] all_outs();
    return {32'(slv_valid), 16'(slv_instr), |slv_addr, |slv_wdata, |slv_wstrb, |imemory_rdata,
            imemory_ready, imemory_err, |dmemory_rdata, dmemory_ready, dmemory_err};
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1;
    req(0, 1, 32'h0000_0000, 0, 0);
    #2;
    chk("reset outputs zero", all_outs(), 0);
    tick();
    rst = 1'b1;
    tick();
    // instruction read, slave 0 answers two cycles later
    lat[0] = 2;
    exp_issue(0, 1, 32'h40, 0, 0);
    exp_rsp(0, 32'h1234_5678, 0);
    req(0, 1, 32'h0000_0040, 0, 0);
    #2;
    chk("t033 zero-latency slv_valid", slv_valid, 4'b0001);
    chk("t033 slv_addr0", slv_addr[31:0], 32'h40);
    tick();
    drain("t033");
    chk("t033 ready latency", 64'(rdy_log[0][$] - iss_log[0][$]), 2);
    // contention on slave 1, fixed priority picks data master first
    lat[1] = 3;
`ifndef MEM_XBAR_RR_EN
    exp_issue(1, 0, 32'h10, 32'hDEAD_BEEF, 4'hF);
    exp_issue(1, 1, 32'h20, 0, 0);
    exp_rsp(1, 32'hA000_0010, 0);
    exp_rsp(0, 32'hA000_0020, 0);
    req(1, 0, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF);
    req(0, 1, 32'h1000_0020, 0, 0);
    #2;
    chk("t034 only data master issued", slv_valid, 4'b0010);
    tick();
    drain("t034");
    chk("t034 waiting issue cycle after ready", 64'(iss_log[1][$]), 64'(rdy_log[1][$-1] + 1));
`else
    // round-robin: contention winners alternate D, I, D
    lat[2] = 1;
    for (int r = 0; r < 3; r++) begin
      logic [31:0] od = 32'(r * 16);
      logic [31:0] oi = 32'(r * 16 + 8);
      if (r == 1) begin
        exp_issue(2, 1, oi, 0, 0);
        exp_issue(2, 0, od, 0, 0);
      end else begin
        exp_issue(2, 0, od, 0, 0);
        exp_issue(2, 1, oi, 0, 0);
      end
      exp_rsp(1, 32'hB000_0000 + od, 0);
      exp_rsp(0, 32'hB000_0000 + oi, 0);
      req(1, 0, 32'h2000_0000 + od, 0, 0);
      req(0, 1, 32'h2000_0000 + oi, 0, 0);
      #2;
      chk($sformatf("t035 round %0d winner instr flag", r), slv_instr[2], r == 1);
      tick();
      drain("t035");
    end
`endif
    // independent slaves proceed concurrently
    lat[0] = 1;
    lat[3] = 4;
    exp_issue(0, 1, 32'h100, 0, 0);
    exp_issue(3, 0, 32'h200, 0, 0);
    exp_rsp(0, 32'h1234_5738, 0);
    exp_rsp(1, 32'hC000_0200, 0);
    req(0, 1, 32'h0000_0100, 0, 0);
    req(1, 0, 32'h3000_0200, 0, 0);
    #2;
    chk("t036 both slv_valid", slv_valid, 4'b1001);
    tick();
    drain("t036");
    chk("t036 same issue cycle", 64'(iss_log[0][$]), 64'(iss_log[3][$]));
    chk("t036 independent completion", 64'(rdy_log[0][$] + 3), 64'(rdy_log[3][$]));
    // unmapped write returns an error beat the next cycle
    exp_rsp(1, 32'h0, 1);
    req(1, 0, 32'h5000_0000, 32'h1111_1111, 4'hF);
    #2;
    chk("t037 no slv_valid", slv_valid, 0);
    chk("t037 no same-cycle ready", dmemory_ready, 0);
    tick();
    chk("t037 error beat", {dmemory_ready, dmemory_err, dmemory_rdata}, {1'b1, 1'b1, 32'h0});
    drain("t037");
    // reset while the data master is busy on slave 1
    lat[1] = 5;
    exp_issue(1, 0, 32'h0, 32'hCAFE_F00D, 4'hF);
    req(1, 0, 32'h1000_0000, 32'hCAFE_F00D, 4'hF);
    tick();
    tick();
    rst = 1'b0;
    req(0, 1, 32'h0000_0000, 0, 0);
    #1;
    chk("t038 outputs zero in reset", all_outs(), 0);
    tick();
    rst = 1'b1;
    k = 0;
    while (!slv_ready[1] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t038 stray slv_ready seen", slv_ready[1], 1);
    chk("t038 stray ignored", {imemory_ready, dmemory_ready, imemory_err, dmemory_err}, 0);
    tick();
    lat[1] = 1;
    exp_issue(1, 0, 32'h30, 0, 0);
    exp_rsp(1, 32'hA000_0030, 0);
    req(1, 0, 32'h1000_0030, 0, 0);
    #2;
    chk("t038 slave 1 free after reset", slv_valid, 4'b0010);
    tick();
    drain("t038");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_xbar.md
MEM_XBAR -- requirements
Module: mem_xbar

Interface
REQ-001 Parameter NSLV, 4, number of slave regions (1..8).
REQ-002 Parameter ADDR_W, 32, address width.
REQ-003 Parameter DATA_W, 32, data width; strobe width DATA_W/8.
REQ-004 Parameter SLV_BASE, {0x3000_0000,0x2000_0000,0x1000_0000,0x0000_0000}, packed NSLV*ADDR_W region bases (slot i = bits [i*ADDR_W +: ADDR_W]).
REQ-005 Parameter SLV_SIZE, all 0x1000_0000, packed NSLV*ADDR_W region sizes, power of two, base size-aligned.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 clk  in  1  clock; all state on rising edge.
REQ-008 imemory_valid/instr/addr/wdata/wstrb  in  1/1/ADDR_W/DATA_W/DATA_W/8  instruction-master request.
REQ-009 imemory_rdata/ready/err  out  DATA_W/1/1  instruction-master response.
REQ-010 dmemory_valid/instr/addr/wdata/wstrb  in  1/1/ADDR_W/DATA_W/DATA_W/8  data-master request.
REQ-011 dmemory_rdata/ready/err  out  DATA_W/1/1  data-master response.
REQ-012 slv_valid/instr  out  NSLV each  per-slave request strobe and instr flag.
REQ-013 slv_addr/wdata/wstrb  out  NSLV*ADDR_W/NSLV*DATA_W/NSLV*DATA_W/8  per-slave request fields.
REQ-014 slv_rdata/ready  in  NSLV*DATA_W/NSLV  per-slave response.

Function
REQ-015 Master valid is a one-cycle pulse; master issues no new request before its ready; the xbar SHALL capture every request and never drop one.
REQ-016 Decode: region i hit when SLV_BASE[i] <= addr < SLV_BASE[i]+SLV_SIZE[i]; lowest index wins on overlap; forwarded slv_addr = addr - SLV_BASE[i].
REQ-017 Per-master FSM states IDLE, PEND, BUSY, DERR.
REQ-018 IDLE: valid to free slave with grant -> slv_valid same cycle (zero added latency), go BUSY; valid not granted or slave busy -> latch request, go PEND; unmapped -> DERR.
REQ-019 PEND: issue latched request first cycle slave is free and granted; go BUSY.
REQ-020 BUSY: route owning slave's rdata/ready to master combinationally; on ready go IDLE, slave freed.
REQ-021 DERR: next cycle ready=1, err=1, rdata=0 for one cycle; go IDLE.
REQ-022 One outstanding transaction per slave; slave busy from issue cycle through its ready cycle; a waiting request issues no earlier than the cycle after ready.
REQ-023 Both masters independent: different slaves SHALL proceed concurrently.
REQ-024 slv_valid is a one-cycle pulse per transaction; non-owning master outputs rdata=0, ready=0, err=0.
REQ-025 slv_ready from a slave with no owner SHALL be ignored.

Reset
REQ-026 On rst=0, asynchronously: both FSMs IDLE, latched requests cleared, all slaves free, round-robin pointer to data master.
REQ-027 During reset all outputs 0: slv_valid, slv_instr, slv_addr, slv_wdata, slv_wstrb, imemory_*/dmemory_* rdata/ready/err.
REQ-028 Reset mid-transaction abandons it; a late slv_ready after release is ignored per REQ-025.

Configuration
REQ-029 Macro MEM_XBAR_RR_EN defined: per-slave round-robin; on simultaneous contention the master not granted last time on that slave wins.
REQ-030 MEM_XBAR_RR_EN undefined: fixed priority, data master always wins; pointer logic absent.

Structure
REQ-031 Package mem_xbar_pkg holds FSM state enum, master index constants (IMST=0, DMST=1), max NSLV constant.
REQ-032 Sub-module mem_xbar_dec: combinational address decoder (one-hot hit, miss flag, offset), instantiated once per master.

Verification
REQ-033 Instr read 0x0000_0040, slave 0 ready after 2 cycles rdata 0x1234_5678 -> slv_addr[0]=0x40 same cycle, imemory_ready with 0x1234_5678, dmemory idle.
REQ-034 Both masters pulse to slave 1 same cycle (fixed priority) -> dmemory issued first; imemory issued cycle after slave 1 ready; both complete, none lost.
REQ-035 With MEM_XBAR_RR_EN, three back-to-back contention rounds on slave 2 -> grants alternate D,I,D.
REQ-036 imemory to slave 0, dmemory to slave 3 same cycle -> both slv_valid same cycle, independent completion.
REQ-037 dmemory write to 0x5000_0000 (unmapped) -> no slv_valid, next cycle dmemory_ready=1, err=1, rdata=0.
REQ-038 rst asserted while dmemory BUSY on slave 1 -> all outputs 0 immediately; post-reset stray slv_ready[1] produces no master ready.
